// File: rtl/updn_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : updn_counter_pkg
// Description : Shared enums and parameter defaults for the up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
package updn_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int c_DEFAULT_WIDTH    = 8;
    localparam int c_DEFAULT_PRESCALE = 1;

endpackage : updn_counter_pkg
`default_nettype wire

// File: rtl/updn_counter_prescale.sv
`default_nettype none
// ============================================================================
// Module      : cnt_prescale
// Description : Counts enabled cycles; tick is high on every PRESCALE-th one.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_prescale #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int                c_CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(PRESCALE - 1);

    logic [c_CW-1:0] r_count;
    logic            w_tick;

    // With PRESCALE=1 the counter sits at zero and every enabled cycle ticks.
    assign w_tick = en && (r_count == c_LAST);
    assign tick   = w_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (restart) begin
            r_count <= '0;
        end else if (en) begin
            if (w_tick) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + c_CW'(1);
            end
        end
    end

endmodule : cnt_prescale
`default_nettype wire

// File: rtl/updn_counter.sv
`default_nettype none
// ============================================================================
// Module      : updn_counter
// Description : Prescaled up/down counter with wrap or saturate boundary mode.
//               Saturation support is built only when UPDN_COUNTER_SAT_EN is
//               defined; otherwise sat is ignored and the counter always wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module updn_counter
    import updn_counter_pkg::*;
#(
    parameter int               WIDTH    = c_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
    parameter int               PRESCALE = c_DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dwn_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             sat,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             at_max,
    output logic             at_zero
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;

    logic             w_tick;
    logic             w_restart;
    dir_e             w_dir;
    mode_e            w_mode;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_ld_val;
    logic [WIDTH-1:0] w_step_val;
    logic             w_step_tc;

    assign w_restart = clr | ld;
    assign w_dir     = dir_e'(up_dwn_n);

`ifdef UPDN_COUNTER_SAT_EN
    assign w_mode = sat ? MODE_SAT : MODE_WRAP;
`else
    logic w_unused_sat;
    assign w_unused_sat = sat;
    assign w_mode       = MODE_WRAP;
`endif

    cnt_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .restart (w_restart),
        .tick    (w_tick)
    );

    assign w_at_max  = (r_cnt == MAX);
    assign w_at_zero = (r_cnt == '0);
    assign w_ld_val  = (ld_val > MAX) ? MAX : ld_val;

    // A step at a boundary always flags tc, whether it wraps or holds.
    always_comb begin
        w_step_val = r_cnt;
        w_step_tc  = 1'b0;
        case (w_dir)
            DIR_UP: begin
                if (w_at_max) begin
                    w_step_tc  = 1'b1;
                    w_step_val = (w_mode == MODE_SAT) ? MAX : '0;
                end else begin
                    w_step_val = r_cnt + WIDTH'(1);
                end
            end
            default: begin
                if (w_at_zero) begin
                    w_step_tc  = 1'b1;
                    w_step_val = (w_mode == MODE_SAT) ? '0 : MAX;
                end else begin
                    w_step_val = r_cnt - WIDTH'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
        end else if (ld) begin
            r_cnt <= w_ld_val;
            r_tc  <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= w_step_val;
            r_tc  <= w_step_tc;
        end else begin
            r_tc  <= 1'b0;
        end
    end

    assign cnt     = r_cnt;
    assign tc      = r_tc;
    assign at_max  = w_at_max;
    assign at_zero = w_at_zero;

endmodule : updn_counter
`default_nettype wire

// File: tb/tb_updn_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_updn_counter
// Description : Directed self-checking bench; dut_a uses PRESCALE=1, dut_b 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updn_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_en = 1'b0, a_up = 1'b1, a_clr = 1'b0, a_ld = 1'b0, a_sat = 1'b0;
    logic [3:0] a_ld_val = 4'd0;
    logic [3:0] a_cnt;
    logic       a_tc, a_at_max, a_at_zero;

    logic       b_en = 1'b0, b_up = 1'b1, b_clr = 1'b0, b_ld = 1'b0, b_sat = 1'b0;
    logic [3:0] b_ld_val = 4'd0;
    logic [3:0] b_cnt;
    logic       b_tc, b_at_max, b_at_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    updn_counter #(.WIDTH(4), .MAX(4'd9), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .up_dwn_n(a_up), .clr(a_clr), .ld(a_ld),
        .ld_val(a_ld_val), .sat(a_sat), .cnt(a_cnt), .tc(a_tc),
        .at_max(a_at_max), .at_zero(a_at_zero)
    );

    updn_counter #(.WIDTH(4), .MAX(4'd9), .PRESCALE(3)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .up_dwn_n(b_up), .clr(b_clr), .ld(b_ld),
        .ld_val(b_ld_val), .sat(b_sat), .cnt(b_cnt), .tc(b_tc),
        .at_max(b_at_max), .at_zero(b_at_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_a_cnt", a_cnt, 0);
        chk("rst_a_tc", a_tc, 0);
        chk("rst_a_at_zero", a_at_zero, 1);
        chk("rst_a_at_max", a_at_max, 0);
        chk("rst_b_cnt", b_cnt, 0);
        #11 rst = 1'b0;

        // Up count to MAX, then wrap with a single tc pulse
        a_en = 1'b1; a_up = 1'b1;
        step(1);
        chk("first_step", a_cnt, 1);
        step(8);
        chk("up9_cnt", a_cnt, 9);
        chk("up9_at_max", a_at_max, 1);
        chk("up9_tc", a_tc, 0);
        step(1);
        chk("wrap_cnt", a_cnt, 0);
        chk("wrap_tc", a_tc, 1);
        step(1);
        chk("after_wrap_cnt", a_cnt, 1);
        chk("after_wrap_tc", a_tc, 0);

        // Down wrap from zero
        a_ld = 1'b1; a_ld_val = 4'd0;
        step(1);
        chk("ld0_cnt", a_cnt, 0);
        chk("ld0_tc", a_tc, 0);
        a_ld = 1'b0; a_up = 1'b0;
        step(1);
        chk("dnwrap_cnt", a_cnt, 9);
        chk("dnwrap_tc", a_tc, 1);
        step(2);
        chk("dn2_cnt", a_cnt, 7);
        chk("dn2_tc", a_tc, 0);

        // Saturate mode (honoured only when the feature is built in)
        a_ld = 1'b1; a_ld_val = 4'd9;
        step(1);
        chk("ld9_cnt", a_cnt, 9);
        a_ld = 1'b0; a_sat = 1'b1; a_up = 1'b1;
`ifdef UPDN_COUNTER_SAT_EN
        step(1); chk("sat_up1_cnt", a_cnt, 9); chk("sat_up1_tc", a_tc, 1);
        step(1); chk("sat_up2_cnt", a_cnt, 9); chk("sat_up2_tc", a_tc, 1);
        step(1); chk("sat_up3_cnt", a_cnt, 9); chk("sat_up3_tc", a_tc, 1);
`else
        step(1); chk("sat_up1_cnt", a_cnt, 0); chk("sat_up1_tc", a_tc, 1);
        step(1); chk("sat_up2_cnt", a_cnt, 1); chk("sat_up2_tc", a_tc, 0);
        step(1); chk("sat_up3_cnt", a_cnt, 2); chk("sat_up3_tc", a_tc, 0);
`endif
        a_ld = 1'b1; a_ld_val = 4'd0;
        step(1);
        a_ld = 1'b0; a_up = 1'b0;
        step(1);
`ifdef UPDN_COUNTER_SAT_EN
        chk("sat_dn_cnt", a_cnt, 0);
`else
        chk("sat_dn_cnt", a_cnt, 9);
`endif
        chk("sat_dn_tc", a_tc, 1);
        a_sat = 1'b0;

        // Load clamp and clr-over-ld priority without a tc pulse
        a_en = 1'b0; a_ld = 1'b1; a_ld_val = 4'hF;
        step(1);
        chk("ldF_cnt", a_cnt, 9);
        chk("ldF_at_max", a_at_max, 1);
        a_en = 1'b1; a_up = 1'b1; a_clr = 1'b1;
        step(1);
        chk("clr_ld_cnt", a_cnt, 0);
        chk("clr_ld_tc", a_tc, 0);
        a_clr = 1'b0; a_ld = 1'b0; a_en = 1'b0;
        a_ld_val = 4'd3;
        step(3);
        chk("hold_cnt", a_cnt, 0);

        // Asynchronous reset during a tc pulse
        a_ld = 1'b1; a_ld_val = 4'd9; a_en = 1'b1; a_up = 1'b1;
        step(1);
        a_ld = 1'b0;
        step(1);
        chk("pre_rst_tc", a_tc, 1);
        #3 rst = 1'b1;
        #1;
        chk("rst_tc_abort", a_tc, 0);
        chk("rst_tc_cnt", a_cnt, 0);
        #1 rst = 1'b0;

        // Asynchronous reset at cnt=5, then resume from zero
        a_ld = 1'b1; a_ld_val = 4'd5;
        step(1);
        chk("ld5_cnt", a_cnt, 5);
        a_ld = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("async_rst_cnt", a_cnt, 0);
        #1 rst = 1'b0;
        step(1);
        chk("resume_cnt", a_cnt, 1);
        chk("resume_tc", a_tc, 0);
        a_en = 1'b0;

        // PRESCALE=3: stepping, hold with en low, direction change mid-window
        b_en = 1'b1; b_up = 1'b1;
        step(2);
        chk("ps_e2_cnt", b_cnt, 0);
        step(1);
        chk("ps_e3_cnt", b_cnt, 1);
        step(1);
        b_en = 1'b0;
        step(2);
        chk("ps_hold_cnt", b_cnt, 1);
        b_en = 1'b1;
        step(2);
        chk("ps_e6_cnt", b_cnt, 2);
        step(3);
        chk("ps_e9_cnt", b_cnt, 3);
        chk("ps_e9_tc", b_tc, 0);
        b_up = 1'b0;
        step(2);
        chk("ps_e11_cnt", b_cnt, 3);
        b_up = 1'b1;
        step(1);
        chk("ps_e12_cnt", b_cnt, 4);
        b_clr = 1'b1;
        step(1);
        chk("ps_clr_cnt", b_cnt, 0);
        b_clr = 1'b0;
        step(2);
        chk("ps_restart_cnt", b_cnt, 0);
        step(1);
        chk("ps_restart_step", b_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_updn_counter
`default_nettype wire
